// File: rtl/bin2bcd.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (shift-and-add-3).
// A start/busy/done handshake serialises conversions; operands above 9999 raise ovf.
module bin2bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] B,
    output logic [3:0]  BCD_0,
    output logic [3:0]  BCD_1,
    output logic [3:0]  BCD_2,
    output logic [3:0]  BCD_3,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [13:0] bin_sr;
    logic [19:0] scratch;
    logic [3:0]  iter;
    logic [19:0] adjusted;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    // NOTE: adjusted gets a full default before the loop so no latch is inferred.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            iter    <= '0;
            BCD_0   <= '0;
            BCD_1   <= '0;
            BCD_2   <= '0;
            BCD_3   <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sr  <= B;
                        scratch <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {adjusted[18:0], bin_sr, 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd13)
                        state <= DONE;
                end
                DONE: begin
                    // Lower digits are always valid BCD, so only a ten-thousands digit signals overflow.
                    BCD_0 <= scratch[3:0];
                    BCD_1 <= scratch[7:4];
                    BCD_2 <= scratch[11:8];
                    BCD_3 <= scratch[15:12];
                    ovf   <= (scratch[19:16] != 4'd0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd.sv
// Directed bench for bin2bcd: reset, digit boundaries, overflow, handshake,
// mid-conversion reset and a short batch of random operands against integer arithmetic.
module tb_bin2bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] B;
    logic [3:0]  BCD_0, BCD_1, BCD_2, BCD_3;
    logic        ovf, busy, done;

    int checks   = 0;
    int failures = 0;

    bin2bcd dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .B     (B),
        .BCD_0 (BCD_0),
        .BCD_1 (BCD_1),
        .BCD_2 (BCD_2),
        .BCD_3 (BCD_3),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digits();
        return {BCD_3, BCD_2, BCD_1, BCD_0};
    endfunction

    // Expected packed BCD computed by plain integer division.
    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Accept a conversion, scramble B afterwards, then check latency, busy span and results.
    task automatic run_conv(input logic [13:0] b, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input string tag);
        int          lat;
        int          busy_cnt;
        logic [15:0] prev;
        prev     = digits();
        B        = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        B        = ~b;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            step();
            lat++;
            if (!done && busy) busy_cnt++;
            if (lat == 7) check({tag, "_hold"}, digits(), prev);
        end
        check({tag, "_lat"}, lat, 15);
        check({tag, "_busy"}, busy_cnt, 15);
        check({tag, "_bcd"}, digits(), exp_bcd);
        check({tag, "_ovf"}, ovf, exp_ovf);
        check({tag, "_idle"}, busy, 1'b0);
        step();
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int seen_done;
        int v;

        rst   = 1'b1;
        start = 1'b0;
        B     = '0;
        step();
        step();
        check("rst_bcd", digits(), 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy) seen_done++;
        end
        check("idle_quiet", seen_done, 0);

        run_conv(14'd777,   16'h0777, 1'b0, "b777");
        run_conv(14'd0,     16'h0000, 1'b0, "b0");
        run_conv(14'd9,     16'h0009, 1'b0, "b9");
        run_conv(14'd9999,  16'h9999, 1'b0, "b9999");
        run_conv(14'd1000,  16'h1000, 1'b0, "b1000");
        run_conv(14'd10000, 16'h0000, 1'b1, "b10000");
        run_conv(14'd16383, 16'h6383, 1'b1, "b16383");

        // Mid-conversion start must be ignored.
        B     = 14'd4321;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        B     = 14'd1234;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 5;
        while (!done && lat < 25) begin
            step();
            lat++;
        end
        check("ign_lat", lat, 15);
        check("ign_bcd", digits(), 16'h4321);
        step();
        check("ign_noreq", busy, 1'b0);

        // start held high through done: the next edge accepts a new operand.
        B     = 14'd555;
        start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_lat1", lat, 15);
        check("b2b_bcd1", digits(), 16'h0555);
        B = 14'd42;
        step();
        check("b2b_accept", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_lat2", lat, 15);
        check("b2b_bcd2", digits(), 16'h0042);
        step();

        // Reset at edge N+7 aborts the conversion without a done pulse.
        B     = 14'd2468;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_bcd", digits(), 16'h0000);
        check("abort_ovf", ovf, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) seen_done++;
        end
        check("abort_nodone", seen_done, 0);
        run_conv(14'd8642, 16'h8642, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(16383, 0));
            run_conv(14'(v), ref_bcd(v), (v > 9999), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
